rr_arb128: RTL and testbench

RR_ARB128 -- requirements
Module: rr_arb128

---
 rtl/rr_arb128_pkg.sv | 12 +
 rtl/rr_pick128.sv | 33 +++
 rtl/rr_arb128.sv | 94 +++++++++
 tb/tb_rr_arb128.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rr_arb128_pkg.sv
// Shared constants and FSM state type for the 128-way round-robin arbiter.
package rr_arb128_pkg;

  localparam int NREQ  = 128;
  localparam int IDX_W = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick128.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping,
// found by a lowest-bit search over {req, req masked to bits >= ptr}.
module rr_pick128
  import rr_arb128_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [NREQ-1:0]   masked;
  logic [2*NREQ-1:0] dbl;
  logic              found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    masked   = req & ({NREQ{1'b1}} << ptr);
    dbl      = {req, masked};
    found    = 1'b0;
    pick_idx = '0;
    // Lower half covers ptr..127; upper half supplies the wrapped 0..ptr-1.
    for (int i = 0; i < 2*NREQ; i++) begin
      if (!found && dbl[i]) begin
        pick_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
    pick = found ? (NREQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/rr_arb128.sv
// 128-requester round-robin arbiter with a registered valid/ready grant and
// back-to-back re-arbitration on every accepted grant.
module rr_arb128
  import rr_arb128_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  input  logic            gnt_ready
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic             xfer;
  logic [IDX_W-1:0] arb_ptr;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;

  assign xfer = gnt_valid_q & gnt_ready;

  // On a transfer the picker already sees the advanced pointer this cycle.
  assign arb_ptr = xfer ? gnt_idx_q + IDX_W'(1) : ptr_q;

  rr_pick128 u_pick (
    .req      (req),
    .ptr      (arb_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = pick;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          ptr_d = arb_ptr;
          if (|req) begin
            gnt_d     = pick;
            gnt_idx_d = pick_idx;
          end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb128.sv
// Directed bench for rr_arb128: expected grants are queued as stimulus is
// driven and compared once the DUT has clocked; invariants checked every cycle.
module tb_rr_arb128;
  import rr_arb128_pkg::*;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic            gnt_ready;

  int              tests;
  int              fails;
  logic            started;
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] all_ones;

  rr_arb128 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] bit_n(input int n);
    logic [NREQ-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  // Grant must be zero when not valid and never more than one-hot.
  always @(negedge clk) begin
    if (started) begin
      tests++;
      assert (gnt_valid === 1'b1 || gnt === '0)
      else begin
        fails++;
        $error("FAIL inv_zero_when_invalid: gnt=%h valid=%b required gnt=0", gnt, gnt_valid);
      end
      tests++;
      assert ($onehot0(gnt))
      else begin
        fails++;
        $error("FAIL inv_onehot: gnt=%h required at most one bit set", gnt);
      end
    end
  end

  // Drive one cycle of stimulus; the grant expected after the edge is queued
  // with the stimulus and popped for comparison once the edge has passed.
  task automatic step(input logic r_rst, input logic [NREQ-1:0] r, input logic rdy,
                      input logic [NREQ-1:0] e, input string tag);
    logic [NREQ-1:0] exp_gnt;
    rst       = r_rst;
    req       = r;
    gnt_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    exp_gnt = exp_q.pop_front();
    tests++;
    assert (gnt === exp_gnt)
    else begin
      fails++;
      $error("FAIL %s gnt: got %h expected %h", tag, gnt, exp_gnt);
    end
    tests++;
    assert (gnt_valid === (exp_gnt != '0))
    else begin
      fails++;
      $error("FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, (exp_gnt != '0));
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    started   = 1'b0;
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    all_ones  = '1;

    // Reset state
    step(1'b1, '0, 1'b0, '0, "reset0");
    started = 1'b1;
    step(1'b1, '0, 1'b0, '0, "reset1");

    // Single request, then prove ptr moved to 1 via the next pick
    step(1'b0, bit_n(0), 1'b1, bit_n(0), "single_grant");
    step(1'b0, '0, 1'b1, '0, "single_drain");
    step(1'b0, bit_n(0) | bit_n(1), 1'b0, bit_n(1), "single_ptr1");
    step(1'b0, '0, 1'b1, '0, "single_drain2");

    // Full load from ptr 0: one grant per cycle, wrapping back to 0
    step(1'b1, '0, 1'b0, '0, "reset_full");
    for (int k = 0; k < NREQ; k++) begin
      step(1'b0, all_ones, 1'b1, bit_n(k), "full_load");
    end
    step(1'b0, all_ones, 1'b1, bit_n(0), "full_wrap");
    step(1'b0, '0, 1'b1, '0, "full_drain");

    // Backpressure: ptr is 1; grant 5 held while bit 5 drops, then 9 follows
    step(1'b0, bit_n(5) | bit_n(9), 1'b0, bit_n(5), "bp_first");
    step(1'b0, bit_n(5) | bit_n(9), 1'b0, bit_n(5), "bp_hold1");
    step(1'b0, bit_n(9), 1'b0, bit_n(5), "bp_hold2");
    step(1'b0, bit_n(9), 1'b0, bit_n(5), "bp_hold3");
    step(1'b0, bit_n(9), 1'b0, bit_n(5), "bp_hold4");
    step(1'b0, bit_n(9), 1'b1, bit_n(9), "bp_next");
    step(1'b0, '0, 1'b1, '0, "bp_drain");

    // Wrap-around: accept 126 so ptr=127, then 127 wins and 3 follows
    step(1'b1, '0, 1'b0, '0, "reset_wrap");
    step(1'b0, bit_n(126), 1'b0, bit_n(126), "wrap_setup");
    step(1'b0, bit_n(3) | bit_n(127), 1'b1, bit_n(127), "wrap_127");
    step(1'b0, bit_n(3) | bit_n(127), 1'b1, bit_n(3), "wrap_3");
    step(1'b0, '0, 1'b1, '0, "wrap_drain");

    // Reset beats a simultaneous transfer; ptr must be 0 (20 wins over 41)
    step(1'b1, '0, 1'b0, '0, "reset_mid");
    step(1'b0, bit_n(40), 1'b0, bit_n(40), "mid_grant40");
    step(1'b1, bit_n(40), 1'b1, '0, "mid_reset");
    step(1'b0, bit_n(20) | bit_n(41), 1'b0, bit_n(20), "mid_ptr0");
    step(1'b0, '0, 1'b1, '0, "mid_drain");

    // Idle with ready toggling: no grant, ptr stays at 21 (22 wins over 20)
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, k[0], '0, "idle");
    end
    step(1'b0, bit_n(20) | bit_n(22), 1'b0, bit_n(22), "idle_ptr_held");
    step(1'b0, '0, 1'b1, '0, "idle_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
